// File: rtl/hub_linear_seq.sv
// Self-sequenced folded hybrid unary-binary linear layer: bitstream dot products over FOLD partitions.
// Optional output saturation is enabled by defining HUB_LINEAR_SEQ_SAT_EN.
module hub_linear_seq #(
  parameter int IDIM  = 8,
  parameter int IWID  = 8,
  parameter int ODIM  = 4,
  parameter int FOLD  = 2,
  parameter int RWID  = IWID,
  parameter int CLOG  = RWID,
  parameter int OWID  = IWID,
  parameter int SHIFT = $clog2(IDIM) + CLOG - OWID
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        iValid,
  output logic                        iReady,
  input  logic [IDIM*IWID-1:0]        iFmap,
  input  logic                        wLoad,
  input  logic [ODIM*IDIM*IWID-1:0]   iWeig,
  output logic                        oValid,
  input  logic                        oReady,
  output logic [ODIM*OWID-1:0]        oFmap,
  output logic                        busy,
  output logic [1:0]                  dbg_state_o
);

  // Handshakes: a transfer happens on a rising clk edge where valid and ready are both high.
  localparam int AW = $clog2(IDIM) + 1 + CLOG;
  localparam int CW = $clog2(IDIM) + 1;
  localparam int GS = ODIM / FOLD;
  localparam int PW = (FOLD > 1) ? $clog2(FOLD) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_OUT  = 2'd2
  } state_t;

  state_t            state_q;
  logic [IWID-1:0]   x_q   [IDIM];
  logic [IWID-1:0]   w_q   [ODIM*IDIM];
  logic [AW-1:0]     acc_q [ODIM];
  logic [CLOG-1:0]   wc_q  [IDIM];
  logic [CLOG-1:0]   t_q;
  logic [PW-1:0]     p_q;
  logic              out_vld_q;
  logic [OWID-1:0]   ofm_q [ODIM];

  logic [RWID-1:0]   in_rng;
  logic [IDIM-1:0]   xb;
  logic [RWID-1:0]   w_rng  [IDIM];
  logic [CW-1:0]     cnt    [ODIM];
  logic [AW-1:0]     acc_d  [ODIM];
  logic [OWID-1:0]   scaled [ODIM];
`ifdef HUB_LINEAR_SEQ_SAT_EN
  logic [AW-1:0]     v;
`endif

  function automatic logic [RWID-1:0] bitrev(input logic [RWID-1:0] a);
    logic [RWID-1:0] r;
    for (int i = 0; i < RWID; i++) r[i] = a[RWID-1-i];
    return r;
  endfunction

  always_comb begin
    in_rng = bitrev(RWID'(t_q));
`ifdef HUB_LINEAR_SEQ_SAT_EN
    v = '0;
`endif
    for (int j = 0; j < IDIM; j++) begin
      xb[j]    = x_q[j] > in_rng;
      w_rng[j] = bitrev(RWID'(wc_q[j]));
    end
    for (int o = 0; o < ODIM; o++) begin
      cnt[o] = '0;
      for (int j = 0; j < IDIM; j++)
        cnt[o] = cnt[o] + CW'(xb[j] & (w_q[o*IDIM+j] > w_rng[j]));
      // Only the group owned by the current partition accumulates.
      acc_d[o] = acc_q[o];
      if (state_q == S_RUN && (o / GS) == int'(p_q))
        acc_d[o] = acc_q[o] + AW'(cnt[o]);
`ifdef HUB_LINEAR_SEQ_SAT_EN
      v         = acc_q[o] >> SHIFT;
      scaled[o] = (|(v >> OWID)) ? {OWID{1'b1}} : v[OWID-1:0];
`else
      scaled[o] = OWID'(acc_q[o] >> SHIFT);
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      t_q       <= '0;
      p_q       <= '0;
      out_vld_q <= 1'b0;
      for (int j = 0; j < IDIM; j++) begin
        x_q[j]  <= '0;
        wc_q[j] <= '0;
      end
      for (int i = 0; i < ODIM*IDIM; i++) w_q[i] <= '0;
      for (int o = 0; o < ODIM; o++) begin
        acc_q[o] <= '0;
        ofm_q[o] <= '0;
      end
    end else begin
      case (state_q)
        S_IDLE: begin
          if (wLoad)
            for (int i = 0; i < ODIM*IDIM; i++) w_q[i] <= iWeig[i*IWID +: IWID];
          if (iValid) begin
            for (int j = 0; j < IDIM; j++) begin
              x_q[j]  <= iFmap[j*IWID +: IWID];
              wc_q[j] <= '0;
            end
            for (int o = 0; o < ODIM; o++) acc_q[o] <= '0;
            t_q     <= '0;
            p_q     <= '0;
            state_q <= S_RUN;
          end
        end
        S_RUN: begin
          for (int o = 0; o < ODIM; o++) acc_q[o] <= acc_d[o];
          t_q <= t_q + 1'b1;
          if (t_q == {CLOG{1'b1}}) begin
            for (int j = 0; j < IDIM; j++) wc_q[j] <= '0;
            if (p_q == PW'(FOLD - 1)) state_q <= S_OUT;
            else                      p_q     <= p_q + 1'b1;
          end else begin
            for (int j = 0; j < IDIM; j++)
              if (xb[j]) wc_q[j] <= wc_q[j] + 1'b1;
          end
        end
        S_OUT: begin
          // First OUT cycle registers the scaled result; oValid follows one edge later.
          if (!out_vld_q) begin
            for (int o = 0; o < ODIM; o++) ofm_q[o] <= scaled[o];
            out_vld_q <= 1'b1;
          end else if (oReady) begin
            out_vld_q <= 1'b0;
            state_q   <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    for (int o = 0; o < ODIM; o++) oFmap[o*OWID +: OWID] = ofm_q[o];
  end

  assign iReady      = (state_q == S_IDLE) && !rst;
  assign oValid      = out_vld_q;
  assign busy        = (state_q != S_IDLE);
  assign dbg_state_o = state_q;

endmodule
